l2_cache: RTL and testbench

Set-associative, write-through, write-allocate second-level cache between the L1 cache and main memory. It transfers whole blocks on both sides: a request from L1 is a full block read or a full block write. Read misses fetch the block from memory. Every write is forwarded to memory in the same cycle it is accepted.

---
 rtl/l2_cache_pkg.sv | 13 +
 rtl/l2_cache_lru.sv | 56 +++++
 rtl/l2_cache.sv | 240 ++++++++++++++++++++++++
 tb/tb_l2_cache.sv | 258 +++++++++++++++++++++++++
 4 files changed

// File: rtl/l2_cache_pkg.sv
// l2_cache_pkg: shared types and constants for the L2 cache.
package l2_cache_pkg;

   // Controller states: IDLE accepts requests, FILL waits for a memory block.
   typedef enum logic {
      IDLE = 1'b0,
      FILL = 1'b1
   } state_e;

   // Width of the per-way recency age used by the true-LRU replacement.
   localparam int LRU_AGE_W = 2;

endpackage : l2_cache_pkg

// File: rtl/l2_cache_lru.sv
// l2_cache_lru: per-set true-LRU ages, victim selection and touch update.
// Age 0 is most recently used; age NUM_WAYS-1 is least recently used.
module l2_cache_lru
   import l2_cache_pkg::*;
#(
   parameter int NUM_SETS = 4,
   parameter int NUM_WAYS = 4,
   localparam int SET_W   = $clog2(NUM_SETS),
   localparam int WAY_W   = $clog2(NUM_WAYS)
) (
   input  logic                clk,
   input  logic                rst,
   input  logic [SET_W-1:0]    set_i,
   input  logic [NUM_WAYS-1:0] valid_i,
   output logic [WAY_W-1:0]    victim_o,
   input  logic                touch_i,
   input  logic [WAY_W-1:0]    touch_way_i
);

   logic [LRU_AGE_W-1:0] age_q [NUM_SETS][NUM_WAYS];

   if (NUM_WAYS > (1 << LRU_AGE_W)) begin : g_age_width_err
      $error("l2_cache_lru: NUM_WAYS exceeds the range of LRU_AGE_W");
   end

   // Victim: lowest-numbered invalid way, otherwise the oldest way.
   always_comb begin
      // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latch).
      victim_o = '0;
      for (int w = 0; w < NUM_WAYS; w++) begin
         if (age_q[set_i][w] == LRU_AGE_W'(NUM_WAYS - 1)) victim_o = WAY_W'(w);
      end
      for (int w = NUM_WAYS - 1; w >= 0; w--) begin
         if (!valid_i[w]) victim_o = WAY_W'(w);
      end
   end

   // Touch: touched way becomes youngest, ways younger than it age by one.
   always_ff @(posedge clk) begin
      // NOTE: sequential state uses non-blocking assignments so every reader sees pre-edge values.
      if (rst) begin
         for (int s = 0; s < NUM_SETS; s++) begin
            for (int w = 0; w < NUM_WAYS; w++) age_q[s][w] <= LRU_AGE_W'(w);
         end
      end else if (touch_i) begin
         for (int w = 0; w < NUM_WAYS; w++) begin
            if (WAY_W'(w) == touch_way_i) begin
               age_q[set_i][w] <= '0;
            end else if (age_q[set_i][w] < age_q[set_i][touch_way_i]) begin
               age_q[set_i][w] <= age_q[set_i][w] + 1'b1;
            end
         end
      end
   end

endmodule : l2_cache_lru

// File: rtl/l2_cache.sv
// l2_cache: set-associative, write-through, write-allocate L2 cache with
// whole-block transfers on both sides. All outputs are registered.
// Optional feature macro: L2_CACHE_STATS_EN adds hit_count / miss_count.
module l2_cache
   import l2_cache_pkg::*;
#(
   parameter int DATA_WIDTH    = 32,
   parameter int ADDR_WIDTH    = 11,
   parameter int CACHE_SIZE    = 512,
   parameter int BLOCK_SIZE    = 32,
   parameter int NUM_WAYS      = 4,
   parameter int L1_BLOCK_SIZE = 32
) (
   input  logic                                     clk,
   input  logic                                     rst,
   input  logic [ADDR_WIDTH-1:0]                    l2_cache_addr,
   input  logic [L1_BLOCK_SIZE-1:0][DATA_WIDTH-1:0] l2_cache_data_in,
   output logic [L1_BLOCK_SIZE-1:0][DATA_WIDTH-1:0] l2_cache_data_out,
   input  logic                                     l2_cache_read,
   input  logic                                     l2_cache_write,
   output logic                                     l2_cache_ready,
   output logic                                     l2_hit,
   output logic [ADDR_WIDTH-1:0]                    mem_addr,
   output logic [BLOCK_SIZE-1:0][DATA_WIDTH-1:0]    mem_data_out,
   input  logic [BLOCK_SIZE-1:0][DATA_WIDTH-1:0]    mem_data_in,
   output logic                                     mem_read,
   output logic                                     mem_write,
   input  logic                                     mem_ready,
   input  logic                                     mem_hit
`ifdef L2_CACHE_STATS_EN
   ,
   output logic [31:0]                              hit_count,
   output logic [31:0]                              miss_count
`endif
);

   localparam int NUM_SETS = CACHE_SIZE / (BLOCK_SIZE * NUM_WAYS);
   localparam int SET_W    = $clog2(NUM_SETS);
   localparam int WAY_W    = $clog2(NUM_WAYS);
   localparam int TAG_W    = ADDR_WIDTH - SET_W;

   typedef logic [BLOCK_SIZE-1:0][DATA_WIDTH-1:0] block_t;

   if (L1_BLOCK_SIZE != BLOCK_SIZE) begin : g_block_size_err
      $error("l2_cache: L1_BLOCK_SIZE must equal BLOCK_SIZE");
   end
   if ((NUM_WAYS & (NUM_WAYS - 1)) != 0) begin : g_ways_err
      $error("l2_cache: NUM_WAYS must be a power of 2");
   end

   // Storage
   logic [NUM_WAYS-1:0] valid_q [NUM_SETS];
   logic [TAG_W-1:0]    tag_q   [NUM_SETS][NUM_WAYS];
   block_t              blk_q   [NUM_SETS][NUM_WAYS];

   // Registered state and outputs
   state_e              state_q,        state_d;
   block_t              data_out_q,     data_out_d;
   logic                ready_q,        ready_d;
   logic                hit_q,          hit_d;
   logic [ADDR_WIDTH-1:0] mem_addr_q,   mem_addr_d;
   block_t              mem_data_out_q, mem_data_out_d;
   logic                mem_read_q,     mem_read_d;
   logic                mem_write_q,    mem_write_d;

   // Lookup and array-update controls
   logic [ADDR_WIDTH-1:0] lk_addr;
   logic [SET_W-1:0]      lk_set;
   logic [TAG_W-1:0]      lk_tag;
   logic                  lk_hit;
   logic [WAY_W-1:0]      hit_way;
   logic [WAY_W-1:0]      victim_way;
   logic                  arr_we;
   logic [WAY_W-1:0]      arr_way;
   block_t                arr_data;
   logic                  touch;
   logic [WAY_W-1:0]      touch_way;

   // mem_addr_q holds the latched miss address for the whole FILL.
   assign lk_addr = (state_q == FILL) ? mem_addr_q : l2_cache_addr;
   assign lk_set  = lk_addr[SET_W-1:0];
   assign lk_tag  = lk_addr[ADDR_WIDTH-1:SET_W];

   // Tag compare against every valid way of the indexed set.
   always_comb begin
      lk_hit  = 1'b0;
      hit_way = '0;
      for (int w = 0; w < NUM_WAYS; w++) begin
         if (valid_q[lk_set][w] && tag_q[lk_set][w] == lk_tag) begin
            lk_hit  = 1'b1;
            hit_way = WAY_W'(w);
         end
      end
   end

   l2_cache_lru #(
      .NUM_SETS (NUM_SETS),
      .NUM_WAYS (NUM_WAYS)
   ) u_lru (
      .clk         (clk),
      .rst         (rst),
      .set_i       (lk_set),
      .valid_i     (valid_q[lk_set]),
      .victim_o    (victim_way),
      .touch_i     (touch),
      .touch_way_i (touch_way)
   );

   // Next-state, output and array-update decode.
   always_comb begin
      state_d        = state_q;
      data_out_d     = data_out_q;
      ready_d        = 1'b0;
      hit_d          = 1'b0;
      mem_addr_d     = mem_addr_q;
      mem_data_out_d = mem_data_out_q;
      mem_read_d     = mem_read_q;
      mem_write_d    = 1'b0;
      arr_we         = 1'b0;
      arr_way        = '0;
      arr_data       = '0;
      touch          = 1'b0;
      touch_way      = '0;
      unique case (state_q)
         IDLE: begin
            if (l2_cache_write) begin
               // Write wins over a simultaneous read; posted write-through.
               mem_write_d    = 1'b1;
               mem_addr_d     = l2_cache_addr;
               mem_data_out_d = l2_cache_data_in;
               ready_d        = 1'b1;
               hit_d          = lk_hit;
               arr_we         = 1'b1;
               arr_way        = lk_hit ? hit_way : victim_way;
               arr_data       = l2_cache_data_in;
               touch          = 1'b1;
               touch_way      = arr_way;
            end else if (l2_cache_read) begin
               if (lk_hit) begin
                  data_out_d = blk_q[lk_set][hit_way];
                  ready_d    = 1'b1;
                  hit_d      = 1'b1;
                  touch      = 1'b1;
                  touch_way  = hit_way;
               end else begin
                  mem_addr_d = l2_cache_addr;
                  mem_read_d = 1'b1;
                  state_d    = FILL;
               end
            end
         end
         FILL: begin
            if (mem_ready) begin
               mem_read_d = 1'b0;
               ready_d    = 1'b1;
               state_d    = IDLE;
               if (mem_hit) begin
                  data_out_d = mem_data_in;
                  arr_we     = 1'b1;
                  arr_way    = victim_way;
                  arr_data   = mem_data_in;
                  touch      = 1'b1;
                  touch_way  = victim_way;
               end else begin
                  data_out_d = '0;
               end
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // State and output registers.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q        <= IDLE;
         data_out_q     <= '0;
         ready_q        <= 1'b0;
         hit_q          <= 1'b0;
         mem_addr_q     <= '0;
         mem_data_out_q <= '0;
         mem_read_q     <= 1'b0;
         mem_write_q    <= 1'b0;
      end else begin
         state_q        <= state_d;
         data_out_q     <= data_out_d;
         ready_q        <= ready_d;
         hit_q          <= hit_d;
         mem_addr_q     <= mem_addr_d;
         mem_data_out_q <= mem_data_out_d;
         mem_read_q     <= mem_read_d;
         mem_write_q    <= mem_write_d;
      end
   end

   // Valid bits: cleared on reset, set on allocation.
   always_ff @(posedge clk) begin
      if (rst) begin
         for (int s = 0; s < NUM_SETS; s++) valid_q[s] <= '0;
      end else if (arr_we) begin
         valid_q[lk_set][arr_way] <= 1'b1;
      end
   end

   // Tag and data arrays: written on allocation or write hit.
   always_ff @(posedge clk) begin
      // NOTE: tag/data arrays are not reset; the valid bits alone make stale contents unreachable.
      if (arr_we && !rst) begin
         tag_q[lk_set][arr_way] <= lk_tag;
         blk_q[lk_set][arr_way] <= arr_data;
      end
   end

   assign l2_cache_data_out = data_out_q;
   assign l2_cache_ready    = ready_q;
   assign l2_hit            = hit_q;
   assign mem_addr          = mem_addr_q;
   assign mem_data_out      = mem_data_out_q;
   assign mem_read          = mem_read_q;
   assign mem_write         = mem_write_q;

`ifdef L2_CACHE_STATS_EN
   logic [31:0] hit_count_q, miss_count_q;

   // Response counters, stepping on the same edge that raises ready.
   always_ff @(posedge clk) begin
      if (rst) begin
         hit_count_q  <= '0;
         miss_count_q <= '0;
      end else if (ready_d) begin
         if (hit_d) hit_count_q  <= hit_count_q + 32'd1;
         else       miss_count_q <= miss_count_q + 32'd1;
      end
   end

   assign hit_count  = hit_count_q;
   assign miss_count = miss_count_q;
`endif

endmodule : l2_cache

// File: tb/tb_l2_cache.sv
// tb_l2_cache: directed self-checking bench for l2_cache.
module tb_l2_cache;

   localparam int DW = 32;
   localparam int AW = 11;
   localparam int BS = 32;

   typedef logic [BS-1:0][DW-1:0] block_t;

   logic          clk = 1'b0;
   logic          rst;
   logic [AW-1:0] l2_cache_addr;
   block_t        l2_cache_data_in;
   block_t        l2_cache_data_out;
   logic          l2_cache_read;
   logic          l2_cache_write;
   logic          l2_cache_ready;
   logic          l2_hit;
   logic [AW-1:0] mem_addr;
   block_t        mem_data_out;
   block_t        mem_data_in;
   logic          mem_read;
   logic          mem_write;
   logic          mem_ready;
   logic          mem_hit;
`ifdef L2_CACHE_STATS_EN
   logic [31:0]   hit_count;
   logic [31:0]   miss_count;
`endif

   int checks   = 0;
   int failures = 0;

   l2_cache dut (
      .clk               (clk),
      .rst               (rst),
      .l2_cache_addr     (l2_cache_addr),
      .l2_cache_data_in  (l2_cache_data_in),
      .l2_cache_data_out (l2_cache_data_out),
      .l2_cache_read     (l2_cache_read),
      .l2_cache_write    (l2_cache_write),
      .l2_cache_ready    (l2_cache_ready),
      .l2_hit            (l2_hit),
      .mem_addr          (mem_addr),
      .mem_data_out      (mem_data_out),
      .mem_data_in       (mem_data_in),
      .mem_read          (mem_read),
      .mem_write         (mem_write),
      .mem_ready         (mem_ready),
      .mem_hit           (mem_hit)
`ifdef L2_CACHE_STATS_EN
      ,
      .hit_count         (hit_count),
      .miss_count        (miss_count)
`endif
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
      end
   endtask

   function automatic block_t mk_blk(input logic [31:0] base);
      block_t b;
      for (int i = 0; i < BS; i++) b[i] = base ^ 32'(i);
      return b;
   endfunction

   // Advance one clock; outputs are sampled 1 time unit after the edge.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_read(input logic [AW-1:0] a);
      l2_cache_addr = a;
      l2_cache_read = 1'b1;
      tick();
      l2_cache_read = 1'b0;
   endtask

   task automatic do_write(input logic [AW-1:0] a, input block_t d);
      l2_cache_addr    = a;
      l2_cache_data_in = d;
      l2_cache_write   = 1'b1;
      tick();
      l2_cache_write   = 1'b0;
   endtask

   task automatic mem_respond(input block_t d, input logic ok);
      mem_data_in = d;
      mem_ready   = 1'b1;
      mem_hit     = ok;
      tick();
      mem_ready   = 1'b0;
      mem_hit     = 1'b0;
   endtask

   task automatic do_reset();
      rst = 1'b1;
      tick();
      tick();
      rst = 1'b0;
   endtask

   // Read miss followed by a successful fill of block base^i.
   task automatic miss_fill(input string tag, input logic [AW-1:0] a, input logic [31:0] base);
      do_read(a);
      check({tag, "_mem_read"}, 32'(mem_read), 32'd1);
      check({tag, "_mem_addr"}, 32'(mem_addr), 32'(a));
      mem_respond(mk_blk(base), 1'b1);
      check({tag, "_ready"}, 32'(l2_cache_ready), 32'd1);
      check({tag, "_hit"}, 32'(l2_hit), 32'd0);
      check({tag, "_dout0"}, l2_cache_data_out[0], base);
   endtask

   initial begin
      block_t exp_blk;
      rst              = 1'b1;
      l2_cache_addr    = '0;
      l2_cache_data_in = '0;
      l2_cache_read    = 1'b0;
      l2_cache_write   = 1'b0;
      mem_data_in      = '0;
      mem_ready        = 1'b0;
      mem_hit          = 1'b0;

      // Reset state
      do_reset();
      check("rst_ready",     32'(l2_cache_ready), 32'd0);
      check("rst_hit",       32'(l2_hit),         32'd0);
      check("rst_mem_read",  32'(mem_read),       32'd0);
      check("rst_mem_write", 32'(mem_write),      32'd0);
      check("rst_mem_addr",  32'(mem_addr),       32'd0);
      check("rst_dout0",     l2_cache_data_out[0], 32'd0);
      check("rst_mdo0",      mem_data_out[0],      32'd0);

      // Read miss on 0x00A
      do_read(11'h00A);
      check("miss_mem_read", 32'(mem_read), 32'd1);
      check("miss_mem_addr", 32'(mem_addr), 32'h00A);
      check("miss_ready",    32'(l2_cache_ready), 32'd0);
      // A write strobe during FILL must be ignored; mem_read holds.
      l2_cache_addr  = 11'h015;
      l2_cache_write = 1'b1;
      tick();
      l2_cache_write = 1'b0;
      check("fill_hold_mem_read", 32'(mem_read), 32'd1);
      check("fill_ign_mem_write", 32'(mem_write), 32'd0);
      check("fill_ign_ready",     32'(l2_cache_ready), 32'd0);
      mem_respond(mk_blk(32'hDEADBEEF), 1'b1);
      check("fill_ready",    32'(l2_cache_ready), 32'd1);
      check("fill_hit",      32'(l2_hit),         32'd0);
      check("fill_mem_read", 32'(mem_read),       32'd0);
      check("fill_dout0",    l2_cache_data_out[0],  32'hDEADBEEF);
      check("fill_dout31",   l2_cache_data_out[31], 32'hDEADBEF0);
      tick();
      check("ready_pulse",   32'(l2_cache_ready), 32'd0);
      check("dout_hold",     l2_cache_data_out[0], 32'hDEADBEEF);

      // Read hit on 0x00A
      l2_cache_data_in = '0;
      do_read(11'h00A);
      check("rhit_ready",    32'(l2_cache_ready), 32'd1);
      check("rhit_hit",      32'(l2_hit),         32'd1);
      check("rhit_dout0",    l2_cache_data_out[0],  32'hDEADBEEF);
      check("rhit_dout31",   l2_cache_data_out[31], 32'hDEADBEF0);
      check("rhit_mem_read", 32'(mem_read), 32'd0);

      // Write miss, then write hit, on 0x014
      exp_blk = mk_blk(32'hA5A5A5A5);
      do_write(11'h014, exp_blk);
      check("wmiss_mem_write", 32'(mem_write), 32'd1);
      check("wmiss_ready",     32'(l2_cache_ready), 32'd1);
      check("wmiss_hit",       32'(l2_hit), 32'd0);
      check("wmiss_mem_addr",  32'(mem_addr), 32'h014);
      check("wmiss_mdo_eq",    32'(mem_data_out == exp_blk), 32'd1);
      check("wmiss_mdo31",     mem_data_out[31], 32'hA5A5A5BA);
      tick();
      check("mem_write_pulse", 32'(mem_write), 32'd0);
      check("hit_pulse_clr",   32'(l2_cache_ready), 32'd0);
      do_write(11'h014, mk_blk(32'h5A5A5A5A));
      check("whit_mem_write",  32'(mem_write), 32'd1);
      check("whit_ready",      32'(l2_cache_ready), 32'd1);
      check("whit_hit",        32'(l2_hit), 32'd1);
      do_read(11'h014);
      check("rwhit_hit",       32'(l2_hit), 32'd1);
      check("rwhit_dout0",     l2_cache_data_out[0], 32'h5A5A5A5A);
      check("rwhit_dout1",     l2_cache_data_out[1], 32'h5A5A5A5B);

      // Simultaneous read and write: write wins
      l2_cache_read = 1'b1;
      do_write(11'h018, mk_blk(32'h01234567));
      l2_cache_read = 1'b0;
      check("rw_mem_write", 32'(mem_write), 32'd1);
      check("rw_mem_read",  32'(mem_read),  32'd0);
      check("rw_hit",       32'(l2_hit),    32'd0);
      check("rw_ready",     32'(l2_cache_ready), 32'd1);

      // LRU: fill set 0 with 0x000, 0x004, 0x008, 0x00C
      do_reset();
      miss_fill("f000", 11'h000, 32'h10000000);
      miss_fill("f004", 11'h004, 32'h10000004);
      miss_fill("f008", 11'h008, 32'h10000008);
      miss_fill("f00c", 11'h00C, 32'h1000000C);
      do_read(11'h000);
      check("touch000_hit", 32'(l2_hit), 32'd1);
      miss_fill("f010", 11'h010, 32'h10000010);
      do_read(11'h000);
      check("keep000_hit",  32'(l2_hit), 32'd1);
      check("keep000_dout", l2_cache_data_out[0], 32'h10000000);
      // 0x004 was evicted; memory reports failure -> no allocation, data 0
      do_read(11'h004);
      check("evict004_mem_read", 32'(mem_read), 32'd1);
      mem_respond(mk_blk(32'hFFFFFFFF), 1'b0);
      check("nohit_ready", 32'(l2_cache_ready), 32'd1);
      check("nohit_hit",   32'(l2_hit), 32'd0);
      check("nohit_dout0", l2_cache_data_out[0], 32'd0);
      // Still not allocated; this fill evicts LRU way holding 0x008
      miss_fill("f004b", 11'h004, 32'h20000004);
      do_read(11'h010);
      check("keep010_hit",  32'(l2_hit), 32'd1);
      check("keep010_dout", l2_cache_data_out[0], 32'h10000010);
      do_read(11'h00C);
      check("keep00c_hit",  32'(l2_hit), 32'd1);

      // Reset while in FILL: fill abandoned even with mem_ready present
      do_read(11'h008);
      check("evict008_mem_read", 32'(mem_read), 32'd1);
      rst         = 1'b1;
      mem_data_in = mk_blk(32'h30000008);
      mem_ready   = 1'b1;
      mem_hit     = 1'b1;
      tick();
      rst         = 1'b0;
      mem_ready   = 1'b0;
      mem_hit     = 1'b0;
      check("rstfill_mem_read", 32'(mem_read), 32'd0);
      check("rstfill_ready",    32'(l2_cache_ready), 32'd0);
      tick();
      check("idle_memready_ign", 32'(l2_cache_ready), 32'd0);
      do_read(11'h008);
      check("after_rst_mem_read", 32'(mem_read), 32'd1);
      check("after_rst_ready",    32'(l2_cache_ready), 32'd0);
      mem_respond(mk_blk(32'h40000008), 1'b1);
      check("after_rst_fill_ready", 32'(l2_cache_ready), 32'd1);
      check("after_rst_fill_hit",   32'(l2_hit), 32'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule : tb_l2_cache
